id_issue_buf: RTL and testbench

- Decode-side issue buffer placed directly downstream of the fetch instruction FIFO.
- Pops one two-instruction fetch packet at a time and holds it in an output register.
- Presents the packet to the decoder as two ordered issue lanes; lane0 is always the oldest instruction.
- Splits a packet into two single issues when a privileged instruction must issue alone, and drops invalid second slots (half packets, exception packets).

---
 rtl/id_issue_buf_pkg.sv | 34 +++
 rtl/issue_stat_cnt.sv | 50 +++++
 rtl/id_issue_buf.sv | 178 +++++++++++++++++
 tb/tb_id_issue_buf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_buf_pkg
// Description : Shared constants, FSM state encoding and fetch-packet layout
//               for the decode-side issue buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package id_issue_buf_pkg;

    localparam logic [31:0] C_INST_NOP = 32'h0340_0000;
    localparam logic [31:0] C_PC_RESET = 32'h1c00_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PAIR  = 2'd1,
        ST_HEAD  = 2'd2,
        ST_TAIL  = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [31:0] cookie;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
        logic [1:0]  priv_flag;
        logic [1:0]  branch_flag;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/issue_stat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : issue_stat_cnt
// Description : Free-running issue statistics counters, cleared only by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_stat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_dual,
    input  logic             inc_single,
    input  logic             inc_split,
    input  logic             inc_bubble,
    output logic [WIDTH-1:0] stat_dual,
    output logic [WIDTH-1:0] stat_single,
    output logic [WIDTH-1:0] stat_split,
    output logic [WIDTH-1:0] stat_bubble
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_dual;
    logic [WIDTH-1:0] r_single;
    logic [WIDTH-1:0] r_split;
    logic [WIDTH-1:0] r_bubble;

    // Counters wrap naturally on overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dual   <= '0;
            r_single <= '0;
            r_split  <= '0;
            r_bubble <= '0;
        end else begin
            if (inc_dual)   r_dual   <= r_dual   + C_ONE;
            if (inc_single) r_single <= r_single + C_ONE;
            if (inc_split)  r_split  <= r_split  + C_ONE;
            if (inc_bubble) r_bubble <= r_bubble + C_ONE;
        end
    end

    assign stat_dual   = r_dual;
    assign stat_single = r_single;
    assign stat_split  = r_split;
    assign stat_bubble = r_bubble;

endmodule
`default_nettype wire

// File: rtl/id_issue_buf.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_buf
// Description : Holds one fetch packet and issues it to decode as two ordered
//               lanes, splitting privileged pairs. Optional counters: define
//               ID_ISSUE_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module id_issue_buf
    import id_issue_buf_pkg::*;
#(
`ifdef ID_ISSUE_STAT_EN
    parameter int          STAT_WIDTH = 32,
`endif
    parameter logic [31:0] INST_NOP   = C_INST_NOP,
    parameter logic [31:0] PC_RESET   = C_PC_RESET
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef ID_ISSUE_STAT_EN
    output logic [STAT_WIDTH-1:0] stat_dual,
    output logic [STAT_WIDTH-1:0] stat_single,
    output logic [STAT_WIDTH-1:0] stat_split,
    output logic [STAT_WIDTH-1:0] stat_bubble,
`endif
    input  logic        flush,
    input  logic        fifo_valid,
    output logic        fifo_ready,
    input  logic [31:0] fifo_inst0,
    input  logic [31:0] fifo_inst1,
    input  logic [31:0] fifo_pc,
    input  logic [31:0] fifo_pc_next,
    input  logic [31:0] fifo_badv,
    input  logic [31:0] fifo_cookie_out,
    input  logic [6:0]  fifo_exception,
    input  logic [1:0]  fifo_excp_flag,
    input  logic [1:0]  fifo_priv_flag,
    input  logic [1:0]  fifo_branch_flag,
    input  logic        id_ready,
    output logic        id_valid0,
    output logic        id_valid1,
    output logic [31:0] id_inst0,
    output logic [31:0] id_inst1,
    output logic [31:0] id_pc0,
    output logic [31:0] id_pc1,
    output logic [31:0] id_pc_next,
    output logic [31:0] id_badv,
    output logic [31:0] id_cookie,
    output logic [6:0]  id_exception,
    output logic [1:0]  id_excp_flag,
    output logic [1:0]  id_priv_flag,
    output logic [1:0]  id_branch_flag
);

    issue_state_t r_state;
    fetch_pkt_t   r_pkt;
    logic         r_cnt2;

    logic w_fire;
    logic w_done;
    logic w_cnt2;
    logic w_split;
    logic w_take;

    // A second slot is only usable when fetch ran sequentially with no fault.
    assign w_cnt2  = (fifo_pc_next == fifo_pc + 32'd8) && (fifo_excp_flag == 2'b00);
    assign w_split = w_cnt2 && (fifo_priv_flag != 2'b00);

    assign w_fire     = id_valid0 & id_ready;
    assign w_done     = (r_state == ST_EMPTY) | (w_fire & (r_state != ST_HEAD));
    assign fifo_ready = w_done & ~flush;
    assign w_take     = fifo_valid & fifo_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_EMPTY;
            r_pkt   <= '0;
            r_cnt2  <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_take) begin
            r_state           <= w_split ? ST_HEAD : ST_PAIR;
            r_cnt2            <= w_cnt2;
            r_pkt.inst0       <= fifo_inst0;
            r_pkt.inst1       <= fifo_inst1;
            r_pkt.pc          <= fifo_pc;
            r_pkt.pc_next     <= fifo_pc_next;
            r_pkt.badv        <= fifo_badv;
            r_pkt.cookie      <= fifo_cookie_out;
            r_pkt.exception   <= fifo_exception;
            r_pkt.excp_flag   <= fifo_excp_flag;
            r_pkt.priv_flag   <= fifo_priv_flag;
            r_pkt.branch_flag <= fifo_branch_flag;
        end else if (w_done) begin
            r_state <= ST_EMPTY;
        end else if ((r_state == ST_HEAD) && w_fire) begin
            r_state <= ST_TAIL;
        end
    end

    // Lane decode depends only on held state, so outputs are stable while stalled.
    always_comb begin
        id_valid0      = 1'b0;
        id_valid1      = 1'b0;
        id_inst0       = INST_NOP;
        id_inst1       = INST_NOP;
        id_pc0         = PC_RESET;
        id_pc1         = PC_RESET;
        id_pc_next     = PC_RESET + 32'd8;
        id_badv        = '0;
        id_cookie      = '0;
        id_exception   = '0;
        id_excp_flag   = '0;
        id_priv_flag   = '0;
        id_branch_flag = '0;
        case (r_state)
            ST_PAIR: begin
                id_valid0      = 1'b1;
                id_valid1      = r_cnt2;
                id_inst0       = r_pkt.inst0;
                id_pc0         = r_pkt.pc;
                if (r_cnt2) begin
                    id_inst1 = r_pkt.inst1;
                    id_pc1   = r_pkt.pc + 32'd4;
                end
                id_pc_next     = r_pkt.pc_next;
                id_badv        = r_pkt.badv;
                id_cookie      = r_pkt.cookie;
                id_exception   = r_pkt.exception;
                id_excp_flag   = r_pkt.excp_flag;
                id_priv_flag   = r_pkt.priv_flag;
                id_branch_flag = r_pkt.branch_flag;
            end
            ST_HEAD: begin
                id_valid0      = 1'b1;
                id_inst0       = r_pkt.inst0;
                id_pc0         = r_pkt.pc;
                id_pc_next     = r_pkt.pc + 32'd4;
                id_badv        = r_pkt.badv;
                id_cookie      = r_pkt.cookie;
                id_exception   = r_pkt.exception;
                id_excp_flag   = r_pkt.excp_flag;
                id_priv_flag   = {1'b0, r_pkt.priv_flag[0]};
                id_branch_flag = {1'b0, r_pkt.branch_flag[0]};
            end
            ST_TAIL: begin
                id_valid0      = 1'b1;
                id_inst0       = r_pkt.inst1;
                id_pc0         = r_pkt.pc + 32'd4;
                id_pc_next     = r_pkt.pc_next;
                id_badv        = r_pkt.badv;
                id_cookie      = r_pkt.cookie;
                id_priv_flag   = {1'b0, r_pkt.priv_flag[1]};
                id_branch_flag = {1'b0, r_pkt.branch_flag[1]};
            end
            default: ;
        endcase
    end

`ifdef ID_ISSUE_STAT_EN
    issue_stat_cnt #(
        .WIDTH (STAT_WIDTH)
    ) u_stat (
        .clk         (clk),
        .rstn        (rstn),
        .inc_dual    (w_fire & id_valid1),
        .inc_single  (w_fire & ~id_valid1),
        .inc_split   ((r_state == ST_HEAD) & w_fire & ~flush),
        .inc_bubble  (id_ready & ~id_valid0),
        .stat_dual   (stat_dual),
        .stat_single (stat_single),
        .stat_split  (stat_split),
        .stat_bubble (stat_bubble)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_issue_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_issue_buf
// Description : Table-driven self-checking bench for id_issue_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_issue_buf;

    localparam logic [31:0] N = 32'h0340_0000;
    localparam logic [31:0] R = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_valid = 1'b0;
    logic        fifo_ready;
    logic [31:0] fifo_inst0 = '0, fifo_inst1 = '0, fifo_pc = '0, fifo_pc_next = '0;
    logic [31:0] fifo_badv = '0, fifo_cookie_out = '0;
    logic [6:0]  fifo_exception = '0;
    logic [1:0]  fifo_excp_flag = '0, fifo_priv_flag = '0, fifo_branch_flag = '0;
    logic        id_ready = 1'b1;
    logic        id_valid0, id_valid1;
    logic [31:0] id_inst0, id_inst1, id_pc0, id_pc1, id_pc_next, id_badv, id_cookie;
    logic [6:0]  id_exception;
    logic [1:0]  id_excp_flag, id_priv_flag, id_branch_flag;
`ifdef ID_ISSUE_STAT_EN
    logic [31:0] stat_dual, stat_single, stat_split, stat_bubble;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_issue_buf dut (
        .clk              (clk),
        .rstn             (rstn),
`ifdef ID_ISSUE_STAT_EN
        .stat_dual        (stat_dual),
        .stat_single      (stat_single),
        .stat_split       (stat_split),
        .stat_bubble      (stat_bubble),
`endif
        .flush            (flush),
        .fifo_valid       (fifo_valid),
        .fifo_ready       (fifo_ready),
        .fifo_inst0       (fifo_inst0),
        .fifo_inst1       (fifo_inst1),
        .fifo_pc          (fifo_pc),
        .fifo_pc_next     (fifo_pc_next),
        .fifo_badv        (fifo_badv),
        .fifo_cookie_out  (fifo_cookie_out),
        .fifo_exception   (fifo_exception),
        .fifo_excp_flag   (fifo_excp_flag),
        .fifo_priv_flag   (fifo_priv_flag),
        .fifo_branch_flag (fifo_branch_flag),
        .id_ready         (id_ready),
        .id_valid0        (id_valid0),
        .id_valid1        (id_valid1),
        .id_inst0         (id_inst0),
        .id_inst1         (id_inst1),
        .id_pc0           (id_pc0),
        .id_pc1           (id_pc1),
        .id_pc_next       (id_pc_next),
        .id_badv          (id_badv),
        .id_cookie        (id_cookie),
        .id_exception     (id_exception),
        .id_excp_flag     (id_excp_flag),
        .id_priv_flag     (id_priv_flag),
        .id_branch_flag   (id_branch_flag)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc, pcn;
        logic [1:0]  ef, pf;
        logic        rdy, fl;
        logic        efr, ev0, ev1;
        logic [31:0] ei0, ei1, epc0, epc1, epcn;
        logic [1:0]  epf, eef;
        logic [6:0]  eexc;
    } vec_t;

    function automatic vec_t v(
        input logic fv, input logic [31:0] pc, input logic [31:0] pcn,
        input logic [1:0] ef, input logic [1:0] pf, input logic rdy, input logic fl,
        input logic efr, input logic ev0, input logic ev1,
        input logic [31:0] ei0, input logic [31:0] ei1, input logic [31:0] epc0,
        input logic [31:0] epc1, input logic [31:0] epcn,
        input logic [1:0] epf, input logic [1:0] eef, input logic [6:0] eexc);
        vec_t t;
        t.fv = fv; t.pc = pc; t.pcn = pcn; t.ef = ef; t.pf = pf; t.rdy = rdy; t.fl = fl;
        t.efr = efr; t.ev0 = ev0; t.ev1 = ev1; t.ei0 = ei0; t.ei1 = ei1;
        t.epc0 = epc0; t.epc1 = epc1; t.epcn = epcn; t.epf = epf; t.eef = eef; t.eexc = eexc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    vec_t vecs[17];

    initial begin
        // Instruction words are derived from the PC: inst0 = pc+0x5000_0000, inst1 = pc+0x6000_0000.
        vecs[0]  = v(1, 32'h1c000000, 32'h1c000008, 0, 0, 1, 0, 1, 1, 1, 32'h6c000000, 32'h7c000000, 32'h1c000000, 32'h1c000004, 32'h1c000008, 0, 0, 0);
        vecs[1]  = v(1, 32'h1c000008, 32'h1c000010, 0, 0, 1, 0, 1, 1, 1, 32'h6c000008, 32'h7c000008, 32'h1c000008, 32'h1c00000c, 32'h1c000010, 0, 0, 0);
        vecs[2]  = v(1, 32'h1c000010, 32'h1c000014, 0, 0, 1, 0, 1, 1, 0, 32'h6c000010, N, 32'h1c000010, R, 32'h1c000014, 0, 0, 0);
        vecs[3]  = v(1, 32'h1c000014, 32'h1c00001c, 1, 0, 1, 0, 1, 1, 0, 32'h6c000014, N, 32'h1c000014, R, 32'h1c00001c, 0, 1, 7'h2a);
        vecs[4]  = v(1, 32'h1c00001c, 32'h1c000024, 0, 2, 1, 0, 1, 1, 0, 32'h6c00001c, N, 32'h1c00001c, R, 32'h1c000020, 0, 0, 0);
        vecs[5]  = v(1, 32'h1c000024, 32'h1c00002c, 0, 0, 1, 0, 0, 1, 0, 32'h7c00001c, N, 32'h1c000020, R, 32'h1c000024, 1, 0, 0);
        vecs[6]  = v(1, 32'h1c000024, 32'h1c00002c, 0, 0, 1, 0, 1, 1, 1, 32'h6c000024, 32'h7c000024, 32'h1c000024, 32'h1c000028, 32'h1c00002c, 0, 0, 0);
        vecs[7]  = v(1, 32'h1c00002c, 32'h1c000034, 0, 0, 0, 0, 0, 1, 1, 32'h6c000024, 32'h7c000024, 32'h1c000024, 32'h1c000028, 32'h1c00002c, 0, 0, 0);
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = v(1, 32'h1c00002c, 32'h1c000034, 0, 0, 1, 0, 1, 1, 1, 32'h6c00002c, 32'h7c00002c, 32'h1c00002c, 32'h1c000030, 32'h1c000034, 0, 0, 0);
        vecs[11] = v(1, 32'h1c000034, 32'h1c00003c, 0, 1, 1, 0, 1, 1, 0, 32'h6c000034, N, 32'h1c000034, R, 32'h1c000038, 1, 0, 0);
        vecs[12] = v(1, 32'h1c00003c, 32'h1c000044, 0, 0, 1, 1, 0, 0, 0, N, N, R, R, 32'h1c000008, 0, 0, 0);
        vecs[13] = v(0, 32'h1c00003c, 32'h1c000044, 0, 0, 1, 0, 1, 0, 0, N, N, R, R, 32'h1c000008, 0, 0, 0);
        vecs[14] = v(1, 32'hfffffffc, 32'h00000004, 0, 0, 1, 0, 1, 1, 1, 32'h4ffffffc, 32'h5ffffffc, 32'hfffffffc, 32'h00000000, 32'h00000004, 0, 0, 0);
        vecs[15] = v(1, 32'h1c000040, 32'h1c000048, 0, 2, 1, 0, 1, 1, 0, 32'h6c000040, N, 32'h1c000040, R, 32'h1c000044, 0, 0, 0);
        vecs[16] = v(0, 32'h1c000040, 32'h1c000048, 0, 0, 1, 0, 0, 1, 0, 32'h7c000040, N, 32'h1c000044, R, 32'h1c000048, 1, 0, 0);

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_valid0", {31'd0, id_valid0}, 32'd0);
        chk("rst_valid1", {31'd0, id_valid1}, 32'd0);
        chk("rst_inst0", id_inst0, N);
        chk("rst_pc0", id_pc0, R);
        chk("rst_pc1", id_pc1, R);
        chk("rst_pc_next", id_pc_next, 32'h1c000008);
        chk("rst_badv", id_badv, 32'd0);
        chk("rst_fifo_ready", {31'd0, fifo_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            fifo_valid      = vecs[i].fv;
            fifo_pc         = vecs[i].pc;
            fifo_pc_next    = vecs[i].pcn;
            fifo_inst0      = vecs[i].pc + 32'h5000_0000;
            fifo_inst1      = vecs[i].pc + 32'h6000_0000;
            fifo_badv       = vecs[i].pc ^ 32'hffff_0000;
            fifo_cookie_out = ~vecs[i].pc;
            fifo_excp_flag  = vecs[i].ef;
            fifo_exception  = (vecs[i].ef != 2'b00) ? 7'h2a : 7'h00;
            fifo_priv_flag  = vecs[i].pf;
            id_ready        = vecs[i].rdy;
            flush           = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_fifo_ready", i), {31'd0, fifo_ready}, {31'd0, vecs[i].efr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid0", i), {31'd0, id_valid0}, {31'd0, vecs[i].ev0});
            chk($sformatf("v%0d_valid1", i), {31'd0, id_valid1}, {31'd0, vecs[i].ev1});
            chk($sformatf("v%0d_inst0", i), id_inst0, vecs[i].ei0);
            chk($sformatf("v%0d_inst1", i), id_inst1, vecs[i].ei1);
            chk($sformatf("v%0d_pc0", i), id_pc0, vecs[i].epc0);
            chk($sformatf("v%0d_pc1", i), id_pc1, vecs[i].epc1);
            chk($sformatf("v%0d_pc_next", i), id_pc_next, vecs[i].epcn);
            chk($sformatf("v%0d_priv", i), {30'd0, id_priv_flag}, {30'd0, vecs[i].epf});
            chk($sformatf("v%0d_excp_flag", i), {30'd0, id_excp_flag}, {30'd0, vecs[i].eef});
            chk($sformatf("v%0d_exception", i), {25'd0, id_exception}, {25'd0, vecs[i].eexc});
        end

        // Held packet badv/cookie come from the last captured packet (pc=0x1c000040).
        chk("tail_badv", id_badv, 32'h1c000040 ^ 32'hffff_0000);
        chk("tail_cookie", id_cookie, ~32'h1c000040);

        // Asynchronous reset in the middle of a TAIL cycle.
        @(negedge clk);
        fifo_valid = 1'b0;
        id_ready   = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid0", {31'd0, id_valid0}, 32'd0);
        chk("arst_inst0", id_inst0, N);
        chk("arst_pc0", id_pc0, R);
        chk("arst_pc_next", id_pc_next, 32'h1c000008);
        chk("arst_priv", {30'd0, id_priv_flag}, 32'd0);
        chk("arst_fifo_ready", {31'd0, fifo_ready}, 32'd1);
`ifdef ID_ISSUE_STAT_EN
        chk("arst_stat_dual", stat_dual, 32'd0);
        chk("arst_stat_single", stat_single, 32'd0);
        chk("arst_stat_split", stat_split, 32'd0);
        chk("arst_stat_bubble", stat_bubble, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
